alu_dispatch: RTL and testbench
===============================

// Module: alu_dispatch
// PURPOSE
//   Issue side of the ALU operand interface. Accepts one decoded-register RV32IM R/I-type op
//   (instruction + rs1/rs2 values), builds the 5-bit ALU ctrl code, and drives alu_a/alu_b/alu_ctrl.
//   Counts the op's fixed latency and captures alu_y. Presents the result with rd on a valid/ready
//   port. One op in flight; sits between the register-read stage and writeback.
// PARAMETERS
//   LAT_ALU  1   edges after ALU operand capture until alu_y is valid, RV32I ops (ctrl[3]=0)
//   LAT_MUL  2   same, mul/mulh/mulhsu/mulhu (ctrl[3:2]=2'b10)
//   LAT_DIV  33  same, div/divu/rem/remu (ctrl[3:2]=2'b11)
// PORTS
//   clk        in   1   clock; all state changes on posedge
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   op request
//   in_ready   out  1   high only in IDLE; op accepted on edge with in_valid&in_ready
//   instr      in   32  RV32 instruction word
//   rs1_val    in   32  rs1 operand
//   rs2_val    in   32  rs2 operand, used for R-type only
//   alu_a      out  32  ALU operand a
//   alu_b      out  32  ALU operand b (rs2_val or sign-extended imm)
//   alu_ctrl   out  5   ALU ctrl code
//   alu_y      in   32  ALU result
//   res_valid  out  1   result available
//   res_ready  in   1   writeback accepts result
//   res_data   out  32  captured result; 0 when rd==0 or on error
//   res_rd     out  5   destination register instr[11:7]
//   res_err    out  1   op was illegal/unsupported
// BEHAVIOUR
//   Reset: state=IDLE; alu_a/alu_b/res_data=0, alu_ctrl=0, res_rd=0, res_valid=0, res_err=0, counter=0.
//   Reset mid-op abandons the op; no result is produced.
//   Decode, R-type (opcode 0110011): ctrl = {instr[30], instr[25], instr[14:12]}.
//     Legal codes: 0,1,4,5,6,7,8..15,16 (sub),21 (sra). All other codes are illegal (slt/sltu, 30/25 combos).
//   Decode, I-type (opcode 0010011): alu_b = sign-extended instr[31:20]; ctrl[3]=0.
//     ctrl[4] = instr[30] only when funct3==101; otherwise 0, so addi with imm[10]=1 stays add.
//     funct3 001 needs instr[31:25]==0; 101 needs instr[31:25] in {0, 0100000}.
//     funct3 010/011 illegal. Any other opcode is illegal.
//   Operand registers (alu_a/alu_b/alu_ctrl) load on the accept edge E0.
//     They stay stable until the next accept; the ALU shifter uses b unregistered.
//   FSM:
//     IDLE -> EXEC on legal accept: cnt <= L (L = LAT_ALU/LAT_MUL/LAT_DIV by ctrl[3:2]).
//     IDLE -> DONE on illegal accept: res_err=1, res_data=0; operand registers unchanged.
//     EXEC: cnt decrements each edge while cnt!=0. On the edge with cnt==0:
//       res_data <= (rd==0) ? 0 : alu_y; res_err <= 0; go to DONE.
//       Result is therefore captured at edge E(L+1).
//     DONE: res_valid=1. res_data/res_rd/res_err are held until res_valid&res_ready, then -> IDLE.
//   in_ready is low in EXEC and DONE. Next accept is no earlier than the edge after the handshake.
//   Throughput for an ALU op with res_ready held high: one op per L+3 cycles.
//   Counter width is clog2(max(LAT_*)+1). Simultaneous in_valid during DONE is ignored; no buffering.
//   res_rd is loaded at accept, so it is valid in DONE for legal and illegal ops.
// TESTING
//   add x3,x1,x2 with rs1=5, rs2=7 -> alu_ctrl=0, alu_b=7.
//     res_valid rises after E2; res_data=12, res_rd=3, res_err=0.
//   sub with rs1=3, rs2=5 -> alu_ctrl=5'b10000; res_data=0xFFFFFFFE.
//   srai x4,x1,4 with rs1=0x80000000 -> alu_ctrl=5'b10101, alu_b=4.
//     res_data=0xF8000000.
//   addi imm=0xFFF (instr[30]=1) with rs1=1 -> alu_ctrl=0, alu_b=0xFFFFFFFF; res_data=0.
//   div with LAT_DIV=33 -> in_ready low until handshake; res_valid after E34.
//     Hold res_ready=0 for 5 cycles -> res_data/res_rd stable, no new accept.
//   slt (R-type funct3=010) -> res_err=1, res_data=0, res_valid after E1.
//     A second case: assert rst_n=0 mid-div -> all outputs 0 immediately, in_ready=1 after release.

Source files
------------

// File: rtl/alu_dispatch_if.sv
// alu_dispatch_if: issue-side bundle between register read, the ALU and writeback
//   in_valid/in_ready/instr/rs1_val/rs2_val : op request from register-read
//   alu_a/alu_b/alu_ctrl/alu_y               : ALU operands, ctrl code and result
//   res_valid/res_ready/res_data/res_rd/res_err : result toward writeback
interface alu_dispatch_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_ctrl;
  logic [31:0] alu_y;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [4:0]  res_rd;
  logic        res_err;
  modport slave (
    input  in_valid, instr, rs1_val, rs2_val, alu_y, res_ready,
    output in_ready, alu_a, alu_b, alu_ctrl, res_valid, res_data, res_rd, res_err
  );
  modport master (
    output in_valid, instr, rs1_val, rs2_val, alu_y, res_ready,
    input  in_ready, alu_a, alu_b, alu_ctrl, res_valid, res_data, res_rd, res_err
  );
endinterface

// File: rtl/alu_dispatch.sv
// alu_dispatch: decodes one RV32IM R/I op, drives the ALU, waits its latency, returns the result
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_dispatch_if slave (request in, ALU operands out, result out)
module alu_dispatch #(
  parameter int LAT_ALU = 1,
  parameter int LAT_MUL = 2,
  parameter int LAT_DIV = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_dispatch_if.slave bus
);
  localparam int LAT_MAX = LAT_ALU > LAT_MUL ? (LAT_ALU > LAT_DIV ? LAT_ALU : LAT_DIV)
                                             : (LAT_MUL > LAT_DIV ? LAT_MUL : LAT_DIV);
  localparam int CW = $clog2(LAT_MAX + 1);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t      state, state_nx;
  logic [CW-1:0] cnt, lat;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        is_r, is_i, r_ok, i_ok, legal, acc;
  logic [4:0]  r_ctrl, ctrl;
  logic [31:0] b;
  logic        unused;
  assign unused = ^bus.instr[19:15];
  assign f3     = bus.instr[14:12];
  assign f7     = bus.instr[31:25];
  assign is_r   = bus.instr[6:0] == 7'b0110011;
  assign is_i   = bus.instr[6:0] == 7'b0010011;
  assign r_ctrl = {bus.instr[30], bus.instr[25], f3};
  // slt/sltu and any 30/25 combination outside the M extension or sub/sra are rejected
  assign r_ok   = r_ctrl inside {5'd0, 5'd1, [5'd4:5'd15], 5'd16, 5'd21};
  assign i_ok   = f3 == 3'b001 ? f7 == 7'b0 :
                  f3 == 3'b101 ? (f7 == 7'b0 || f7 == 7'b0100000) :
                  !(f3 inside {3'b010, 3'b011});
  assign legal  = is_r ? r_ok : is_i && i_ok;
  // imm[10] only selects arithmetic shift for srai; for addi etc. it is just an immediate bit
  assign ctrl   = is_r ? r_ctrl : {f3 == 3'b101 && bus.instr[30], 1'b0, f3};
  assign b      = is_r ? bus.rs2_val : {{20{bus.instr[31]}}, bus.instr[31:20]};
  assign lat    = ctrl[3] ? (ctrl[2] ? CW'(LAT_DIV) : CW'(LAT_MUL)) : CW'(LAT_ALU);
  assign acc    = bus.in_valid && bus.in_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE ? (acc ? (legal ? EXEC : DONE) : IDLE) :
               state == EXEC ? (cnt == '0 ? DONE : EXEC) :
               (bus.res_ready ? IDLE : DONE);
  end
  always_comb begin
    bus.in_ready  = state == IDLE;
    bus.res_valid = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.alu_a    <= '0;
      bus.alu_b    <= '0;
      bus.alu_ctrl <= '0;
      bus.res_data <= '0;
      bus.res_rd   <= '0;
      bus.res_err  <= 1'b0;
      cnt          <= '0;
    end else if (acc) begin
      bus.res_rd <= bus.instr[11:7];
      if (legal) begin
        bus.alu_a    <= bus.rs1_val;
        bus.alu_b    <= b;
        bus.alu_ctrl <= ctrl;
        cnt          <= lat;
      end else begin
        bus.res_err  <= 1'b1;
        bus.res_data <= '0;
      end
    end else if (state == EXEC) begin
      if (cnt != '0) cnt <= cnt - 1'b1;
      else begin
        bus.res_data <= bus.res_rd == 5'd0 ? 32'd0 : bus.alu_y;
        bus.res_err  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_dispatch.sv
// tb_alu_dispatch: randomized and directed checks of alu_dispatch against an ISA-level model
module tb_alu_dispatch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  alu_dispatch_if bus();
  alu_dispatch #(.LAT_ALU(1), .LAT_MUL(2), .LAT_DIV(33)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int n_chk = 0;
  int n_fail = 0;
  int age = 0;
  logic [31:0] ea = '0, eb = '0;
  logic [4:0]  ec = '0;
  function automatic logic [31:0] alu_fn(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (c)
      5'd0:  return a + b;
      5'd1:  return a << b[4:0];
      5'd4:  return a ^ b;
      5'd5:  return a >> b[4:0];
      5'd6:  return a | b;
      5'd7:  return a & b;
      5'd16: return a - b;
      5'd21: return $signed(a) >>> b[4:0];
      5'd8:  return a * b;
      5'd9:  begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
      5'd10: begin p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return p[63:32]; end
      5'd11: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      5'd12: begin
        if (b == 0) return '1;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        return $signed(a) / $signed(b);
      end
      5'd13: begin
        if (b == 0) return '1;
        return a / b;
      end
      5'd14: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      5'd15: begin
        if (b == 0) return a;
        return a % b;
      end
      default: return 32'hBAD0BAD0;
    endcase
  endfunction
  function automatic int lat_of(input logic [4:0] c);
    return (c >= 5'd8 && c <= 5'd11) ? 2 : (c >= 5'd12 && c <= 5'd15) ? 33 : 1;
  endfunction
  // external ALU: result is only trustworthy once its latency has elapsed since operand capture
  always @(posedge clk or negedge rst_n)
    if (!rst_n) age <= 0;
    else if (bus.in_valid && bus.in_ready) age <= 0;
    else if (age < 1000) age <= age + 1;
  always_comb bus.alu_y = (age >= lat_of(bus.alu_ctrl)) ? alu_fn(bus.alu_ctrl, bus.alu_a, bus.alu_b) : 32'hBAD0BAD0;
  function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] i_ins(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'h13};
  endfunction
  // mnemonic-level decode: which RV32IM op this is, its ctrl code, operand b and latency
  task automatic ref_model(input logic [31:0] ins, input logic [31:0] r2, output logic ok,
                           output logic [4:0] c, output logic [31:0] b, output int lat);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = ins[14:12];
    f7 = ins[31:25];
    ok = 1'b0;
    c = '0;
    b = '0;
    if (ins[6:0] == 7'h33) begin
      b = r2;
      if (f7 == 7'h01) begin ok = 1'b1; c = 5'd8 + {2'b0, f3}; end
      else if (f7 == 7'h00) begin ok = !(f3 == 3'd2 || f3 == 3'd3); c = {2'b0, f3}; end
      else if (f7 == 7'h20 && f3 == 3'd0) begin ok = 1'b1; c = 5'd16; end
      else if (f7 == 7'h20 && f3 == 3'd5) begin ok = 1'b1; c = 5'd21; end
    end else if (ins[6:0] == 7'h13) begin
      b = {{20{ins[31]}}, ins[31:20]};
      case (f3)
        3'd0, 3'd4, 3'd6, 3'd7: begin ok = 1'b1; c = {2'b0, f3}; end
        3'd1: begin ok = f7 == 7'h00; c = 5'd1; end
        3'd5: begin ok = f7 == 7'h00 || f7 == 7'h20; c = f7 == 7'h20 ? 5'd21 : 5'd5; end
        default: ok = 1'b0;
      endcase
    end
    lat = lat_of(c);
  endtask
  task automatic run_op(input string nm, input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                        input int hold, output logic [31:0] got);
    logic ok;
    logic [4:0] c, rd;
    logic [31:0] b, ed;
    int lat, n;
    ref_model(ins, r2, ok, c, b, lat);
    rd = ins[11:7];
    ed = (ok && rd != 0) ? alu_fn(c, r1, b) : 32'd0;
    if (ok) begin ea = r1; eb = b; ec = c; end
    n = 0;
    while (!bus.in_ready && n < 100) begin @(posedge clk); #1; n++; end
    n_chk++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL %s ready_wait: in_ready=%b required 1", nm, bus.in_ready); end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.instr = ins;
    bus.rs1_val = r1;
    bus.rs2_val = r2;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_chk++;
    if ({bus.alu_a, bus.alu_b, bus.alu_ctrl, bus.in_ready} !== {ea, eb, ec, 1'b0}) begin
      n_fail++;
      $display("FAIL %s operands: a=%h b=%h ctrl=%0d rdy=%b required a=%h b=%h ctrl=%0d rdy=0",
               nm, bus.alu_a, bus.alu_b, bus.alu_ctrl, bus.in_ready, ea, eb, ec);
    end
    n = 0;
    while (!bus.res_valid && n < 60) begin @(posedge clk); #1; n++; end
    n_chk++;
    if (n != (ok ? lat + 1 : 0)) begin n_fail++; $display("FAIL %s latency: %0d edges required %0d", nm, n, ok ? lat + 1 : 0); end
    n_chk++;
    if ({bus.res_data, bus.res_rd, bus.res_err} !== {ed, rd, !ok}) begin
      n_fail++;
      $display("FAIL %s result: data=%h rd=%0d err=%b required data=%h rd=%0d err=%b",
               nm, bus.res_data, bus.res_rd, bus.res_err, ed, rd, !ok);
    end
    got = bus.res_data;
    if (hold > 0) bus.in_valid = 1'b1;
    repeat (hold) begin
      @(posedge clk); #1;
      n_chk++;
      if ({bus.res_valid, bus.in_ready, bus.res_data, bus.res_rd, bus.res_err} !== {1'b1, 1'b0, ed, rd, !ok}) begin
        n_fail++;
        $display("FAIL %s hold: valid=%b rdy=%b data=%h rd=%0d err=%b required 1 0 %h %0d %b",
                 nm, bus.res_valid, bus.in_ready, bus.res_data, bus.res_rd, bus.res_err, ed, rd, !ok);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    n_chk++;
    if ({bus.res_valid, bus.in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL %s handshake: valid=%b rdy=%b required 0 1", nm, bus.res_valid, bus.in_ready);
    end
  endtask
  task automatic test_reset();
    #12;
    n_chk++;
    if ({bus.alu_a, bus.alu_b, bus.alu_ctrl, bus.res_valid, bus.res_data, bus.res_rd, bus.res_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: a=%h b=%h ctrl=%0d valid=%b data=%h rd=%0d err=%b required all 0",
               bus.alu_a, bus.alu_b, bus.alu_ctrl, bus.res_valid, bus.res_data, bus.res_rd, bus.res_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: in_ready=%b required 1", bus.in_ready); end
  endtask
  task automatic test_directed();
    logic [31:0] got;
    run_op("add", r_ins(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'd5, 32'd7, 0, got);
    n_chk++;
    if ({got, bus.alu_ctrl, bus.alu_b} !== {32'd12, 5'd0, 32'd7}) begin
      n_fail++; $display("FAIL add_literal: data=%h ctrl=%0d b=%h required 0000000c 0 00000007", got, bus.alu_ctrl, bus.alu_b);
    end
    run_op("sub", r_ins(7'h20, 5'd2, 5'd1, 3'd0, 5'd3), 32'd3, 32'd5, 0, got);
    n_chk++;
    if ({got, bus.alu_ctrl} !== {32'hFFFFFFFE, 5'b10000}) begin
      n_fail++; $display("FAIL sub_literal: data=%h ctrl=%0d required fffffffe 16", got, bus.alu_ctrl);
    end
    run_op("srai", i_ins(12'h404, 5'd1, 3'd5, 5'd4), 32'h80000000, 32'd0, 0, got);
    n_chk++;
    if ({got, bus.alu_ctrl, bus.alu_b[4:0]} !== {32'hF8000000, 5'b10101, 5'd4}) begin
      n_fail++; $display("FAIL srai_literal: data=%h ctrl=%0d shamt=%0d required f8000000 21 4", got, bus.alu_ctrl, bus.alu_b[4:0]);
    end
    run_op("addi_neg", i_ins(12'hFFF, 5'd1, 3'd0, 5'd5), 32'd1, 32'd0, 0, got);
    n_chk++;
    if ({got, bus.alu_ctrl, bus.alu_b} !== {32'd0, 5'd0, 32'hFFFFFFFF}) begin
      n_fail++; $display("FAIL addi_literal: data=%h ctrl=%0d b=%h required 0 0 ffffffff", got, bus.alu_ctrl, bus.alu_b);
    end
    run_op("add_rd0", r_ins(7'h00, 5'd2, 5'd1, 3'd0, 5'd0), 32'd5, 32'd7, 0, got);
  endtask
  task automatic test_div_hold();
    logic [31:0] got;
    run_op("div_hold", r_ins(7'h01, 5'd2, 5'd1, 3'd4, 5'd6), 32'd100, 32'd7, 5, got);
    n_chk++;
    if (got !== 32'd14) begin n_fail++; $display("FAIL div_literal: data=%h required 0000000e", got); end
  endtask
  task automatic test_illegal();
    logic [31:0] got;
    run_op("slt", r_ins(7'h00, 5'd2, 5'd1, 3'd2, 5'd7), 32'd1, 32'd2, 2, got);
    run_op("slli_bad", i_ins(12'h401, 5'd1, 3'd1, 5'd8), 32'd1, 32'd0, 0, got);
    run_op("lui", 32'h12345237, 32'd1, 32'd2, 0, got);
  endtask
  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'h80000000;
      3: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction
  task automatic test_random();
    logic [6:0] f7s [4] = '{7'h00, 7'h20, 7'h01, 7'h21};
    logic [31:0] ins, got;
    logic [11:0] imm;
    int k;
    for (int i = 0; i < 80; i++) begin
      k = $urandom_range(0, 9);
      if (k < 5) ins = r_ins(f7s[$urandom_range(0, 3)], 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom));
      else if (k < 9) begin
        imm = 12'($urandom);
        if (imm[2:0] == 3'd0) imm[11:5] = f7s[$urandom_range(0, 1)];
        ins = i_ins(imm, 5'($urandom), 3'($urandom), 5'($urandom));
      end else begin
        ins = $urandom;
        ins[6:0] = ($urandom_range(0, 1) == 0) ? 7'h37 : 7'h63;
      end
      run_op("random", ins, pick_val(), pick_val(), $urandom_range(0, 2), got);
    end
  endtask
  task automatic test_back_to_back();
    int last, acc;
    last = -1;
    acc = 0;
    bus.instr = r_ins(7'h00, 5'd2, 5'd1, 3'd0, 5'd5);
    bus.rs1_val = 32'd10;
    bus.rs2_val = 32'd20;
    bus.res_ready = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (bus.in_ready) begin
        if (last >= 0) begin
          n_chk++;
          if (i - last != 4) begin n_fail++; $display("FAIL b2b_gap: %0d cycles required 4", i - last); end
        end
        last = i;
        acc++;
      end
      if (bus.res_valid) begin
        n_chk++;
        if ({bus.res_data, bus.res_err} !== {32'd30, 1'b0}) begin
          n_fail++; $display("FAIL b2b_data: data=%h err=%b required 0000001e 0", bus.res_data, bus.res_err);
        end
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    n_chk++;
    if (acc < 5) begin n_fail++; $display("FAIL b2b_count: %0d accepts required at least 5", acc); end
    repeat (8) begin @(posedge clk); #1; end
    bus.res_ready = 1'b0;
    ea = 32'd10; eb = 32'd20; ec = 5'd0;
  endtask
  task automatic test_reset_mid_op();
    logic [31:0] got;
    int seen;
    @(negedge clk);
    bus.instr = r_ins(7'h01, 5'd2, 5'd1, 3'd5, 5'd9);
    bus.rs1_val = $urandom;
    bus.rs2_val = 32'd3;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    ea = '0; eb = '0; ec = '0;
    #1;
    n_chk++;
    if ({bus.alu_a, bus.alu_b, bus.alu_ctrl, bus.res_valid, bus.res_data, bus.res_rd, bus.res_err} !== '0) begin
      n_fail++;
      $display("FAIL midop_reset: a=%h b=%h ctrl=%0d valid=%b data=%h rd=%0d err=%b required all 0",
               bus.alu_a, bus.alu_b, bus.alu_ctrl, bus.res_valid, bus.res_data, bus.res_rd, bus.res_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midop_ready: in_ready=%b required 1", bus.in_ready); end
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (bus.res_valid) seen++; end
    n_chk++;
    if (seen != 0) begin n_fail++; $display("FAIL midop_abandon: res_valid seen %0d cycles required 0", seen); end
    run_op("post_reset_add", r_ins(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'd40, 32'd2, 0, got);
  endtask
  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    bus.in_valid = 1'b0;
    bus.res_ready = 1'b0;
    bus.instr = '0;
    bus.rs1_val = '0;
    bus.rs2_val = '0;
    test_reset();
    test_directed();
    test_div_hold();
    test_illegal();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
